// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial pattern scanner.
package seq_scan_pkg;

  localparam int PAT_W     = 4;
  localparam int BYTE_W    = 8;
  localparam int CNT_W     = 8;
  localparam int BIT_IDX_W = $clog2(BYTE_W);
  // Fill must be able to represent 0..PAT_W inclusive.
  localparam int FILL_W    = $clog2(PAT_W + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Controller FSM encoding, also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Increment that sticks at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Byte stream into the scanner.
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high. in_data and in_last are meaningful only while
// in_valid is high and must stay stable until the transfer happens.
// in_ready may rise and fall independently of in_valid.
interface seq_scan_ctrl_if
  import seq_scan_pkg::*;
();

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/pattern_match.sv
// Bit-history shift register, fill tracking and pattern comparator.
// match is combinational for the bit being shifted this cycle; the
// controller registers it.
module pattern_match
  import seq_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clr,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  // A match needs PAT_W-1 valid bits already held so the incoming bit
  // completes a full window.
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_next;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Oldest bit sits in the MSB, newest bit enters at the LSB.
  assign hist_next = {hist_q[PAT_W-2:0], bit_in};
  assign match     = shift_en && (fill_q >= FILL_ARM) && (hist_next == pattern);

  // Next history and fill: clear wins, otherwise advance on each shift.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = hist_next;
      if (match && !overlap) begin
        // Non-overlapping mode: bits of this match cannot start another.
        fill_d = '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  // History and fill registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serial pattern scan controller: accepts bytes, serialises them MSB
// first (one bit per cycle) and counts occurrences of a 4-bit pattern.
module seq_scan_ctrl
  import seq_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  seq_scan_ctrl_if.slave   s_in,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state
);

  state_e                 state_q, state_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]      data_q, data_d;
  logic                   last_q, last_d;
  logic [PAT_W-1:0]       pattern_q, pattern_d;
  logic                   overlap_q, overlap_d;
  logic                   pulse_q, pulse_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   accept;
  logic                   shift_en;
  logic                   bit_in;
  logic                   match;

  // start overrides everything, so it blocks both acceptance and shifting.
  assign s_in.in_ready = (state_q == ST_WAIT) && !start;
  assign accept        = s_in.in_valid && s_in.in_ready;
  assign shift_en      = (state_q == ST_SHIFT) && !start;
  assign bit_in        = data_q[bit_idx_q];

  pattern_match u_match (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .bit_in   (bit_in),
    .clr      (start),
    .pattern  (pattern_q),
    .overlap  (overlap_q),
    .match    (match)
  );

  // FSM next state plus byte/config capture.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    last_d    = last_q;
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    if (start) begin
      // Restart from any state; an in-flight byte is dropped.
      state_d   = ST_WAIT;
      bit_idx_d = '0;
      pattern_d = cfg_pattern;
      overlap_d = cfg_overlap;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_WAIT: begin
          if (accept) begin
            data_d    = s_in.in_data;
            last_d    = s_in.in_last;
            bit_idx_d = BIT_IDX_W'(BYTE_W - 1);
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_idx_q != '0) begin
            bit_idx_d = bit_idx_q - 1'b1;
          end else begin
            state_d = last_q ? ST_DONE : ST_WAIT;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Match pulse is the registered comparator result; count saturates.
  always_comb begin
    pulse_d = match;
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (match) begin
      count_d = sat_inc(count_q);
    end
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      pattern_q <= '0;
      overlap_q <= 1'b0;
      pulse_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      last_q    <= last_d;
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      pulse_q   <= pulse_d;
      count_q   <= count_d;
    end
  end

  assign match_pulse = pulse_q;
  assign match_count = count_q;
  assign busy        = (state_q == ST_WAIT) || (state_q == ST_SHIFT);
  assign done        = (state_q == ST_DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: table vectors, hand-written
// corner sequences and randomized streams against a bit-window model.
module tb_seq_scan_ctrl;
  import seq_scan_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic       match_pulse;
  logic [7:0] match_count;
  logic       busy;
  logic       done;
  state_e     dbg_state;

  seq_scan_ctrl_if s_if ();

  seq_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .s_in        (s_if),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  int          hs_log[$];
  int          pulse_log[$];
  int          done_log[$];
  logic [31:0] exp_q[$];
  int          exp_bits_q[$];
  logic [7:0]  stim_q[$];

  typedef struct {
    logic [3:0]  pat;
    bit          ov;
    int          nb;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] mask;  // bit i set: stream bit i completes a match
    int          cnt;
  } vec_t;
  vec_t vecs[10];

  // Monitor: record handshakes, pulses and done by cycle number.
  always @(negedge clk) begin
    if (s_if.in_valid && s_if.in_ready) hs_log.push_back(cyc);
    if (match_pulse) pulse_log.push_back(cyc);
    if (done) done_log.push_back(cyc);
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Slide a window over the MSB-first bit stream; a match is a full
  // 4-bit window equal to the pattern. Non-overlapping mode forgets
  // the window after each match.
  task automatic model_stream(input logic [3:0] pat, input bit ov);
    bit         win[$];
    logic [7:0] byt;
    exp_bits_q.delete();
    for (int b = 0; b < stim_q.size(); b++) begin
      byt = stim_q[b];
      for (int p = 7; p >= 0; p--) begin
        win.push_back(byt[p]);
        if (win.size() > 4) void'(win.pop_front());
        if (win.size() == 4 && {win[0], win[1], win[2], win[3]} == pat) begin
          exp_bits_q.push_back(b * 8 + (7 - p));
          if (!ov) win.delete();
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [3:0] pat, input bit ov);
    @(posedge clk); #1;
    start = 1'b1; cfg_pattern = pat; cfg_overlap = ov;
    @(posedge clk); #1;
    start = 1'b0;
    // Config is only sampled with start; scramble it afterwards.
    cfg_pattern = 4'($urandom);
    cfg_overlap = 1'($urandom);
  endtask

  // Returns just after the edge that completed the transfer.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (s_if.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", int'(ok), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic run_stream(input logic [3:0] pat, input bit ov, input int gap_max);
    bit ok;
    hs_log.delete(); pulse_log.delete(); done_log.delete();
    do_start(pat, ov);
    for (int b = 0; b < stim_q.size(); b++) begin
      s_if.in_valid = 1'b1;
      s_if.in_data  = stim_q[b];
      s_if.in_last  = (b == stim_q.size() - 1);
      wait_accept(ok);
      s_if.in_valid = 1'b0;
      s_if.in_data  = 8'h00;
      s_if.in_last  = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk); #1;
      end
    end
    wait_done();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Compare logged activity with exp_bits_q (stream bit indices).
  task automatic verify(input string name, input int exp_cnt, input bit spacing);
    int mism;
    int last_hs;
    check({name, "_bytes"}, hs_log.size(), stim_q.size());
    if (spacing) begin
      mism = 0;
      for (int b = 1; b < hs_log.size(); b++)
        if (hs_log[b] - hs_log[b-1] != 9) mism++;
      check({name, "_spacing"}, mism, 0);
    end
    // Bit p of a byte accepted in cycle T shifts in T+1+p, pulses T+2+p.
    exp_q.delete();
    foreach (exp_bits_q[i])
      if (exp_bits_q[i] / 8 < hs_log.size())
        exp_q.push_back(32'(hs_log[exp_bits_q[i] / 8] + 2 + exp_bits_q[i] % 8));
    check({name, "_npulses"}, pulse_log.size(), exp_bits_q.size());
    mism = 0;
    foreach (pulse_log[i]) begin
      if (exp_q.size() == 0) mism++;
      else if (exp_q.pop_front() != 32'(pulse_log[i])) mism++;
    end
    mism += exp_q.size();
    check({name, "_pulse_cycles"}, mism, 0);
    check({name, "_count"}, int'(match_count), exp_cnt);
    last_hs = (hs_log.size() > 0) ? hs_log[hs_log.size() - 1] : -100;
    check({name, "_done_once"}, done_log.size(), 1);
    check({name, "_done_cycle"}, (done_log.size() > 0) ? done_log[0] : -1, last_hs + 9);
  endtask

  // ---------------- test sequence ----------------
  logic [3:0] r_pat;
  bit         r_ov;
  int         r_nb;
  int         sc;
  bit         ok;

  initial begin
    vecs[0] = '{4'b0110, 1'b1, 1, 8'h6C, 8'h00, 16'h0048, 2};
    vecs[1] = '{4'b0110, 1'b0, 1, 8'h6C, 8'h00, 16'h0008, 1};
    vecs[2] = '{4'b0110, 1'b1, 2, 8'h03, 8'h00, 16'h0100, 1};
    vecs[3] = '{4'b1111, 1'b1, 1, 8'hFF, 8'h00, 16'h00F8, 5};
    vecs[4] = '{4'b1111, 1'b0, 1, 8'hFF, 8'h00, 16'h0088, 2};
    vecs[5] = '{4'b1010, 1'b1, 2, 8'hAA, 8'hAA, 16'hAAA8, 7};
    vecs[6] = '{4'b1010, 1'b0, 2, 8'hAA, 8'hAA, 16'h8888, 4};
    vecs[7] = '{4'b0001, 1'b1, 1, 8'h11, 8'h00, 16'h0088, 2};
    vecs[8] = '{4'b0101, 1'b1, 1, 8'h00, 8'h00, 16'h0000, 0};
    vecs[9] = '{4'b1001, 1'b1, 2, 8'h01, 8'h3F, 16'h0400, 1};

    rst = 1'b0; start = 1'b0; cfg_pattern = 4'h0; cfg_overlap = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_data = 8'h00; s_if.in_last = 1'b0;

    // Reset values, before any clock edge.
    #3;
    check("rst_in_ready", int'(s_if.in_ready), 0);
    check("rst_pulse", int'(match_pulse), 0);
    check("rst_count", int'(match_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    #19 rst = 1'b1;

    // Idle without start must not accept.
    s_if.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", int'(s_if.in_ready), 0);
    end
    s_if.in_valid = 1'b0;

    // Table vectors, bytes back to back.
    for (int v = 0; v < 10; v++) begin
      stim_q.delete();
      stim_q.push_back(vecs[v].b0);
      if (vecs[v].nb > 1) stim_q.push_back(vecs[v].b1);
      exp_bits_q.delete();
      for (int i = 0; i < 16; i++) if (vecs[v].mask[i]) exp_bits_q.push_back(i);
      run_stream(vecs[v].pat, vecs[v].ov, 0);
      verify($sformatf("vec%0d", v), vecs[v].cnt, 1'b1);
    end

    // Saturation: 557 matches, count sticks at 255, pulses keep going.
    stim_q.delete();
    repeat (70) stim_q.push_back(8'h00);
    model_stream(4'b0000, 1'b1);
    run_stream(4'b0000, 1'b1, 0);
    verify("sat", 255, 1'b1);
    check("sat_pulses_total", pulse_log.size(), 557);

    // Abort with start while bit_idx=4.
    hs_log.delete(); pulse_log.delete(); done_log.delete();
    do_start(4'b0110, 1'b1);
    s_if.in_valid = 1'b1; s_if.in_data = 8'h6C; s_if.in_last = 1'b1;
    wait_accept(ok);
    s_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("abort_in_ready", int'(s_if.in_ready), 1);
    check("abort_count", int'(match_count), 0);
    check("abort_state", int'(dbg_state), int'(ST_WAIT));
    repeat (12) @(posedge clk);
    check("abort_no_done", done_log.size(), 0);
    check("abort_no_pulse", pulse_log.size(), 0);

    // start in the same cycle as in_valid: byte waits for the next cycle.
    @(posedge clk); #1;
    hs_log.delete(); pulse_log.delete(); done_log.delete();
    start = 1'b1; cfg_pattern = 4'b0110; cfg_overlap = 1'b1;
    s_if.in_valid = 1'b1; s_if.in_data = 8'h6C; s_if.in_last = 1'b1;
    @(negedge clk);
    sc = cyc;
    check("coinc_ready_low", int'(s_if.in_ready), 0);
    @(posedge clk); #1 start = 1'b0;
    wait_accept(ok);
    s_if.in_valid = 1'b0;
    wait_done();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("coinc_accept_cycle", (hs_log.size() > 0) ? hs_log[0] : -1, sc + 1);
    check("coinc_count", int'(match_count), 2);
    check("coinc_done", done_log.size(), 1);

    // Randomized streams against the model.
    for (int r = 0; r < 8; r++) begin
      r_pat = 4'($urandom);
      r_ov  = 1'($urandom);
      r_nb  = $urandom_range(1, 6);
      stim_q.delete();
      for (int b = 0; b < r_nb; b++) stim_q.push_back(8'($urandom));
      model_stream(r_pat, r_ov);
      run_stream(r_pat, r_ov, 12);
      verify($sformatf("rand%0d", r), (exp_bits_q.size() > 255) ? 255 : exp_bits_q.size(), 1'b0);
    end

    // Asynchronous reset in the middle of the second byte.
    hs_log.delete(); pulse_log.delete(); done_log.delete();
    do_start(4'b0110, 1'b1);
    s_if.in_valid = 1'b1; s_if.in_data = 8'h6C; s_if.in_last = 1'b0;
    wait_accept(ok);
    s_if.in_last = 1'b1;
    wait_accept(ok);
    s_if.in_valid = 1'b0;
    check("prerst_count", int'(match_count), 2);
    repeat (2) @(posedge clk);
    #3;
    check("prerst_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    check("midrst_pulse", int'(match_pulse), 0);
    check("midrst_count", int'(match_count), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_in_ready", int'(s_if.in_ready), 0);
    check("midrst_state", int'(dbg_state), int'(ST_IDLE));
    @(posedge clk); #3 rst = 1'b1;
    s_if.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("postrst_in_ready", int'(s_if.in_ready), 0);
    end
    check("postrst_state", int'(dbg_state), int'(ST_IDLE));
    s_if.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    check("postrst_no_done", done_log.size(), 0);
    check("postrst_pulses", pulse_log.size(), 2);
    check("postrst_count", int'(match_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so a stuck design cannot hang the run.
  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at cycle %0d, %0d/%0d passed so far", cyc, n_pass, n_checks);
    $fatal(1);
  end

endmodule
